// File: rtl/wb_pkg.sv
//==============================================================================
// Module  : wb_pkg
// Purpose : Shared definitions for the writeback stage: MEM->WB bus layout
//           helpers, writeback FSM state encoding and exception codes.
// Bus layout (MSB..LSB): {pc, gr_we, dest, result, exc, ecode, ertn}
// Revision: 1.0  initial release
//==============================================================================
`default_nettype none

package wb_pkg;

   // Writeback FSM: SHADOW is the single cycle after a flush retire in which
   // whatever MEM still presents is wrong-path.
   typedef enum logic [0:0] {
      ST_RUN    = 1'b0,
      ST_SHADOW = 1'b1
   } wb_state_e;

   // LoongArch-style exception codes
   localparam logic [5:0] ECODE_INT = 6'h00;
   localparam logic [5:0] ECODE_PIL = 6'h01;
   localparam logic [5:0] ECODE_PIS = 6'h02;
   localparam logic [5:0] ECODE_PIF = 6'h03;
   localparam logic [5:0] ECODE_PME = 6'h04;
   localparam logic [5:0] ECODE_PPI = 6'h07;
   localparam logic [5:0] ECODE_ADE = 6'h08;
   localparam logic [5:0] ECODE_ALE = 6'h09;
   localparam logic [5:0] ECODE_SYS = 6'h0b;
   localparam logic [5:0] ECODE_BRK = 6'h0c;
   localparam logic [5:0] ECODE_INE = 6'h0d;
   localparam logic [5:0] ECODE_IPE = 6'h0e;
   localparam logic [5:0] ECODE_FPD = 6'h0f;

   // Total bus width: pc + dest + result + ecode + {gr_we, exc, ertn}
   function automatic int bus_w(input int pc_w, input int raddr_w,
                                input int xlen, input int ecode_w);
      return pc_w + raddr_w + xlen + ecode_w + 3;
   endfunction

   // Field LSB offsets, packed from the LSB upwards
   localparam int OFF_ERTN  = 0;
   localparam int OFF_ECODE = 1;

   function automatic int off_exc(input int ecode_w);
      return ecode_w + 1;
   endfunction

   function automatic int off_result(input int ecode_w);
      return ecode_w + 2;
   endfunction

   function automatic int off_dest(input int xlen, input int ecode_w);
      return xlen + ecode_w + 2;
   endfunction

   function automatic int off_gr_we(input int raddr_w, input int xlen, input int ecode_w);
      return raddr_w + xlen + ecode_w + 2;
   endfunction

   function automatic int off_pc(input int raddr_w, input int xlen, input int ecode_w);
      return raddr_w + xlen + ecode_w + 3;
   endfunction

endpackage

`default_nettype wire

// File: rtl/wb_stage_ex.sv
//==============================================================================
// Module  : wb_stage_ex
// Purpose : Parametrised pipeline writeback stage. Accepts one instruction
//           per cycle from MEM, commits register writes through a shared
//           write port with backpressure, retires exceptions/ERTN with a
//           one-cycle flush, and counts retired instructions.
// Ports   :
//   clk, reset           clock, synchronous active-high reset
//   me_to_wb_valid/bus   instruction from MEM; wb_allow_in is the accept
//   rf_ready             write port grant; rf_we/rf_waddr/rf_wdata commit
//   wb_dest              destination for ID hazard detection
//   wb_flush/_ertn       one-cycle flush (ERTN qualifier), with
//   wb_exc_pc/wb_ecode   PC and code of the flushing instruction
//   retire_count         instructions retired since reset (wraps)
//   debug_wb_*           difftest trace ports
// Revision: 1.0  initial release
//==============================================================================
`default_nettype none

module wb_stage_ex
   import wb_pkg::*;
#(
   parameter int XLEN    = 32,
   parameter int RADDR_W = 5,
   parameter int PC_W    = 32,
   parameter int ECODE_W = 6,
   parameter int CNT_W   = 64
) (
   input  logic                                          clk,
   input  logic                                          reset,
   input  logic                                          me_to_wb_valid,
   input  logic [bus_w(PC_W, RADDR_W, XLEN, ECODE_W)-1:0] me_to_wb_bus,
   output logic                                          wb_allow_in,
   input  logic                                          rf_ready,
   output logic                                          rf_we,
   output logic [RADDR_W-1:0]                            rf_waddr,
   output logic [XLEN-1:0]                               rf_wdata,
   output logic [RADDR_W-1:0]                            wb_dest,
   output logic                                          wb_flush,
   output logic                                          wb_flush_ertn,
   output logic [PC_W-1:0]                               wb_exc_pc,
   output logic [ECODE_W-1:0]                            wb_ecode,
   output logic [CNT_W-1:0]                              retire_count,
   output logic [PC_W-1:0]                               debug_wb_pc,
   output logic [XLEN/8-1:0]                             debug_wb_rf_we,
   output logic [RADDR_W-1:0]                            debug_wb_rf_wnum,
   output logic [XLEN-1:0]                               debug_wb_rf_wdata
);

   localparam int OFF_EXC    = off_exc(ECODE_W);
   localparam int OFF_RESULT = off_result(ECODE_W);
   localparam int OFF_DEST   = off_dest(XLEN, ECODE_W);
   localparam int OFF_GR_WE  = off_gr_we(RADDR_W, XLEN, ECODE_W);
   localparam int OFF_PC     = off_pc(RADDR_W, XLEN, ECODE_W);

   // Control state
   wb_state_e          state_q, state_d;
   logic               wb_valid_q, wb_valid_d;
   logic [CNT_W-1:0]   retire_count_q, retire_count_d;

   // Payload (not reset; qualified by wb_valid_q)
   logic [PC_W-1:0]    pc_q, pc_d;
   logic               gr_we_q, gr_we_d;
   logic [RADDR_W-1:0] dest_q, dest_d;
   logic [XLEN-1:0]    result_q, result_d;
   logic               exc_q, exc_d;
   logic [ECODE_W-1:0] ecode_q, ecode_d;
   logic               ertn_q, ertn_d;

   logic wr_req;
   logic ready_go;
   logic flush;
   logic in_shadow;
   logic allow_in;
   logic load;
   logic retire;

   always_comb begin
      wr_req    = wb_valid_q && gr_we_q && !exc_q && !ertn_q;
      ready_go  = !wr_req || rf_ready;
      flush     = wb_valid_q && (exc_q || ertn_q);
      in_shadow = (state_q == ST_SHADOW);
      retire    = wb_valid_q && ready_go;

      // SHADOW always accepts so MEM drains its wrong-path content.
      allow_in  = !wb_valid_q || ready_go || in_shadow;

      // Whatever MEM hands over while the flush is in progress (the flush
      // cycle itself and the shadow cycle) was fetched down the wrong path,
      // so it is accepted but not kept.
      load      = me_to_wb_valid && allow_in && !flush && !in_shadow;

      wb_valid_d = allow_in ? load : wb_valid_q;

      pc_d     = pc_q;
      gr_we_d  = gr_we_q;
      dest_d   = dest_q;
      result_d = result_q;
      exc_d    = exc_q;
      ecode_d  = ecode_q;
      ertn_d   = ertn_q;
      if (load) begin
         pc_d     = me_to_wb_bus[OFF_PC +: PC_W];
         gr_we_d  = me_to_wb_bus[OFF_GR_WE];
         dest_d   = me_to_wb_bus[OFF_DEST +: RADDR_W];
         result_d = me_to_wb_bus[OFF_RESULT +: XLEN];
         exc_d    = me_to_wb_bus[OFF_EXC];
         ecode_d  = me_to_wb_bus[OFF_ECODE +: ECODE_W];
         ertn_d   = me_to_wb_bus[OFF_ERTN];
      end

      // SHADOW is a single cycle; a flush can only retire out of RUN.
      state_d = ST_RUN;
      if (!in_shadow && flush) begin
         state_d = ST_SHADOW;
      end

      retire_count_d = retire_count_q + {{(CNT_W-1){1'b0}}, retire};
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q        <= ST_RUN;
         wb_valid_q     <= 1'b0;
         retire_count_q <= '0;
      end else begin
         state_q        <= state_d;
         wb_valid_q     <= wb_valid_d;
         retire_count_q <= retire_count_d;
      end
   end

   always_ff @(posedge clk) begin
      pc_q     <= pc_d;
      gr_we_q  <= gr_we_d;
      dest_q   <= dest_d;
      result_q <= result_d;
      exc_q    <= exc_d;
      ecode_q  <= ecode_d;
      ertn_q   <= ertn_d;
   end

   assign wb_allow_in   = allow_in;
   assign rf_we         = wr_req && rf_ready;
   assign rf_waddr      = dest_q;
   assign rf_wdata      = result_q;
   assign wb_dest       = (wb_valid_q && gr_we_q) ? dest_q : '0;

   // An exception takes priority over ERTN when both are flagged.
   assign wb_flush      = flush;
   assign wb_flush_ertn = flush && ertn_q && !exc_q;
   assign wb_exc_pc     = flush ? pc_q : '0;
   assign wb_ecode      = flush ? ecode_q : '0;

   assign retire_count  = retire_count_q;

   assign debug_wb_pc       = pc_q;
   assign debug_wb_rf_we    = {(XLEN/8){rf_we}};
   assign debug_wb_rf_wnum  = dest_q;
   assign debug_wb_rf_wdata = result_q;

endmodule

`default_nettype wire
